// File: rtl/stack_sequencer.sv
// Stack-port initiator: turns CALL/RET/INT/RTI pulses into 16-bit push/pop beat
// sequences and reassembles the popped return PC and flags.
module stack_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int FLAG_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    call_req,
    input  logic                    ret_req,
    input  logic                    int_req,
    input  logic                    rti_req,
    input  logic [2*DATA_WIDTH-1:0] pc_in,
    input  logic [FLAG_WIDTH-1:0]   flags_in,
    input  logic [DATA_WIDTH-1:0]   mem_data_in,
    output logic                    memory_push,
    output logic                    memory_pop,
    output logic [DATA_WIDTH-1:0]   write_data,
    output logic                    busy,
    output logic [2*DATA_WIDTH-1:0] pc_out,
    output logic                    pc_valid,
    output logic [FLAG_WIDTH-1:0]   flags_out,
    output logic                    flags_valid
);

    typedef enum logic [2:0] {
        IDLE, PUSH_FLAGS, PUSH_HI, PUSH_LO, POP_LO, POP_HI, POP_FLAGS
    } state_t;

    state_t                  state, state_next;
    logic [2*DATA_WIDTH-1:0] pc_hold;
    logic [FLAG_WIDTH-1:0]   flag_hold;
    logic                    int_pending;
    logic                    is_rti;
    logic                    idle, take_int, take_rti, take_call, take_ret, accept;

    // A pending interrupt counts as int_req and so outranks any fresh request.
    assign idle      = (state == IDLE);
    assign take_int  = idle && (int_req || int_pending);
    assign take_rti  = idle && !take_int && rti_req;
    assign take_call = idle && !take_int && !rti_req && call_req;
    assign take_ret  = idle && !take_int && !rti_req && !call_req && ret_req;
    assign accept    = take_int || take_rti || take_call || take_ret;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        memory_push = 1'b0;
        memory_pop  = 1'b0;
        write_data  = '0;
        busy        = (state != IDLE);
        case (state)
            IDLE: begin
                if (take_int)                  state_next = PUSH_FLAGS;
                else if (take_rti || take_ret) state_next = POP_LO;
                else if (take_call)            state_next = PUSH_HI;
            end
            PUSH_FLAGS: begin
                memory_push = 1'b1;
                write_data  = {{(DATA_WIDTH-FLAG_WIDTH){1'b0}}, flag_hold};
                state_next  = PUSH_HI;
            end
            PUSH_HI: begin
                memory_push = 1'b1;
                write_data  = pc_hold[2*DATA_WIDTH-1:DATA_WIDTH];
                state_next  = PUSH_LO;
            end
            PUSH_LO: begin
                memory_push = 1'b1;
                write_data  = pc_hold[DATA_WIDTH-1:0];
                state_next  = IDLE;
            end
            POP_LO: begin
                memory_pop = 1'b1;
                state_next = POP_HI;
            end
            POP_HI: begin
                memory_pop = 1'b1;
                state_next = is_rti ? POP_FLAGS : IDLE;
            end
            POP_FLAGS: begin
                memory_pop = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_hold     <= '0;
            flag_hold   <= '0;
            int_pending <= 1'b0;
            is_rti      <= 1'b0;
            pc_out      <= '0;
            flags_out   <= '0;
            pc_valid    <= 1'b0;
            flags_valid <= 1'b0;
        end else begin
            // Completion pulses land in the first IDLE cycle after the last pop.
            pc_valid    <= (state == POP_HI && !is_rti) || (state == POP_FLAGS);
            flags_valid <= (state == POP_FLAGS);
            if (accept) begin
                pc_hold <= pc_in;
                is_rti  <= take_rti;
            end
            if (take_int)
                flag_hold <= flags_in;
            if (take_int)
                int_pending <= 1'b0;
            else if (!idle && int_req)
                int_pending <= 1'b1;
            case (state)
                POP_LO:    pc_out[DATA_WIDTH-1:0]            <= mem_data_in;
                POP_HI:    pc_out[2*DATA_WIDTH-1:DATA_WIDTH] <= mem_data_in;
                POP_FLAGS: flags_out                         <= mem_data_in[FLAG_WIDTH-1:0];
                default:   ;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: directed cycle vectors, an async-reset abort
// sequence, then random requests against a beat-list model with a memory stack.
module tb_stack_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        call_req = 0, ret_req = 0, int_req = 0, rti_req = 0;
    logic [31:0] pc_in = '0;
    logic [2:0]  flags_in = '0;
    logic [15:0] mem_data_in = '0;
    logic        memory_push, memory_pop, busy, pc_valid, flags_valid;
    logic [15:0] write_data;
    logic [31:0] pc_out;
    logic [2:0]  flags_out;

    int n_chk = 0;
    int n_pass = 0;

    stack_sequencer #(.DATA_WIDTH(16), .FLAG_WIDTH(3)) dut (
        .clk(clk), .reset(reset),
        .call_req(call_req), .ret_req(ret_req), .int_req(int_req), .rti_req(rti_req),
        .pc_in(pc_in), .flags_in(flags_in), .mem_data_in(mem_data_in),
        .memory_push(memory_push), .memory_pop(memory_pop), .write_data(write_data),
        .busy(busy), .pc_out(pc_out), .pc_valid(pc_valid),
        .flags_out(flags_out), .flags_valid(flags_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  req;   // {int, rti, call, ret}
        logic [31:0] pc;
        logic [2:0]  fl;
        logic [15:0] md;
        logic [55:0] exp;
    } vec_t;

    typedef struct packed {
        logic        ps;
        logic        pp;
        logic [15:0] wd;
        logic [1:0]  fin;   // 1: RET completes after this beat, 2: RTI
        logic [31:0] pc;
        logic [2:0]  fl;
    } beat_t;

    vec_t        vq[$];
    beat_t       bq[$];
    logic [15:0] wstk[$];
    logic [15:0] mstk[$];

    function automatic logic [55:0] pk(logic ps, logic pp, logic bz, logic pv, logic fv,
                                       logic [15:0] wd, logic [31:0] po, logic [2:0] fo);
        return {ps, pp, bz, pv, fv, wd, po, fo};
    endfunction

    function automatic vec_t v(logic [3:0] r, logic [31:0] pc, logic [2:0] fl, logic [15:0] md,
                               logic [55:0] e);
        return {r, pc, fl, md, e};
    endfunction

    function automatic logic [55:0] outs();
        return {memory_push, memory_pop, busy, pc_valid, flags_valid, write_data, pc_out, flags_out};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    endtask

    task automatic mpop(output logic [15:0] w);
        w = '0;
        if (wstk.size() > 0) w = wstk.pop_back();
    endtask

    initial begin
        logic [55:0] z;
        z = '0;
        // Inputs applied in cycle i; exp is what is visible in the following cycle.
        for (int i = 0; i < 5; i++) vq.push_back(v(4'b0000, 0, 0, 0, z));
        vq.push_back(v(4'b0010, 32'h0001_2345, 0, 0, pk(1,0,1,0,0,16'h0001,0,0)));
        vq.push_back(v(4'b0000, 0, 0, 0, pk(1,0,1,0,0,16'h2345,0,0)));
        vq.push_back(v(4'b0000, 0, 0, 0, z));
        vq.push_back(v(4'b0001, 0, 0, 0, pk(0,1,1,0,0,0,0,0)));
        vq.push_back(v(4'b0000, 0, 0, 16'h2345, pk(0,1,1,0,0,0,32'h0000_2345,0)));
        vq.push_back(v(4'b0000, 0, 0, 16'h0001, pk(0,0,0,1,0,0,32'h0001_2345,0)));
        vq.push_back(v(4'b0000, 0, 0, 0, pk(0,0,0,0,0,0,32'h0001_2345,0)));
        vq.push_back(v(4'b1000, 32'h0000_00A0, 3'b101, 0, pk(1,0,1,0,0,16'h0005,32'h0001_2345,0)));
        vq.push_back(v(4'b0000, 0, 0, 0, pk(1,0,1,0,0,16'h0000,32'h0001_2345,0)));
        vq.push_back(v(4'b0000, 0, 0, 0, pk(1,0,1,0,0,16'h00A0,32'h0001_2345,0)));
        vq.push_back(v(4'b0000, 0, 0, 0, pk(0,0,0,0,0,0,32'h0001_2345,0)));
        vq.push_back(v(4'b0100, 0, 0, 0, pk(0,1,1,0,0,0,32'h0001_2345,0)));
        vq.push_back(v(4'b0000, 0, 0, 16'h00A0, pk(0,1,1,0,0,0,32'h0001_00A0,0)));
        vq.push_back(v(4'b0000, 0, 0, 16'h0000, pk(0,1,1,0,0,0,32'h0000_00A0,0)));
        vq.push_back(v(4'b0000, 0, 0, 16'h0005, pk(0,0,0,1,1,0,32'h0000_00A0,3'b101)));
        vq.push_back(v(4'b0000, 0, 0, 0, pk(0,0,0,0,0,0,32'h0000_00A0,3'b101)));
        // CALL and INT together: INT wins, CALL dropped
        vq.push_back(v(4'b1010, 32'h0000_1111, 3'b010, 0, pk(1,0,1,0,0,16'h0002,32'hA0,5)));
        vq.push_back(v(4'b0000, 0, 0, 0, pk(1,0,1,0,0,16'h0000,32'hA0,5)));
        vq.push_back(v(4'b0000, 0, 0, 0, pk(1,0,1,0,0,16'h1111,32'hA0,5)));
        vq.push_back(v(4'b0000, 0, 0, 0, pk(0,0,0,0,0,0,32'hA0,5)));
        // INT during the second CALL beat is held and taken in the first IDLE cycle
        vq.push_back(v(4'b0010, 32'h0000_2222, 0, 0, pk(1,0,1,0,0,16'h0000,32'hA0,5)));
        vq.push_back(v(4'b0000, 0, 0, 0, pk(1,0,1,0,0,16'h2222,32'hA0,5)));
        vq.push_back(v(4'b1000, 32'h0000_9999, 3'b110, 0, pk(0,0,0,0,0,0,32'hA0,5)));
        vq.push_back(v(4'b0000, 32'h0000_3333, 3'b011, 0, pk(1,0,1,0,0,16'h0003,32'hA0,5)));
        vq.push_back(v(4'b0000, 0, 0, 0, pk(1,0,1,0,0,16'h0000,32'hA0,5)));
        vq.push_back(v(4'b0000, 0, 0, 0, pk(1,0,1,0,0,16'h3333,32'hA0,5)));
        vq.push_back(v(4'b0000, 0, 0, 0, pk(0,0,0,0,0,0,32'hA0,5)));
        vq.push_back(v(4'b0000, 0, 0, 0, pk(0,0,0,0,0,0,32'hA0,5)));
        // RET while busy is ignored
        vq.push_back(v(4'b0010, 32'h0000_4444, 0, 0, pk(1,0,1,0,0,16'h0000,32'hA0,5)));
        vq.push_back(v(4'b0001, 0, 0, 0, pk(1,0,1,0,0,16'h4444,32'hA0,5)));
        vq.push_back(v(4'b0000, 0, 0, 0, pk(0,0,0,0,0,0,32'hA0,5)));
        vq.push_back(v(4'b0000, 0, 0, 0, pk(0,0,0,0,0,0,32'hA0,5)));

        repeat (2) @(negedge clk);
        chk("reset_state", {8'h0, outs()}, 64'h0);
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            {int_req, rti_req, call_req, ret_req} = vq[i].req;
            pc_in = vq[i].pc; flags_in = vq[i].fl; mem_data_in = vq[i].md;
            @(posedge clk); @(negedge clk);
            chk($sformatf("vec%0d", i), {8'h0, outs()}, {8'h0, vq[i].exp});
        end

        // Asynchronous reset in PUSH_HI of an INT sequence
        int_req = 1; pc_in = 32'h5555_AAAA; flags_in = 3'b111;
        @(posedge clk); @(negedge clk);
        int_req = 0;
        chk("rst_pf", {47'h0, memory_push, write_data}, {47'h0, 1'b1, 16'h0007});
        @(posedge clk); @(negedge clk);
        chk("rst_ph", {47'h0, memory_push, write_data}, {47'h0, 1'b1, 16'h5555});
        #2 reset = 1'b1;
        #1 chk("rst_async", {8'h0, outs()}, 64'h0);
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); @(negedge clk);
            chk($sformatf("rst_after%0d", i), {61'h0, memory_push, memory_pop, busy}, 64'h0);
        end

        // Random requests against the beat-list model
        begin
            logic        nv_p, nv_f, pend;
            logic [31:0] e_pc;
            logic [2:0]  e_fl;
            nv_p = 0; nv_f = 0; pend = 0; e_pc = '0; e_fl = '0;
            for (int k = 0; k < 600; k++) begin
                beat_t       b;
                bit          idle_now;
                logic        ir, rr, cr, tr;
                logic [31:0] rpc;
                logic [2:0]  rfl;
                logic [15:0] w0, w1, w2;
                idle_now = (bq.size() == 0);
                b = '0;
                if (!idle_now) b = bq.pop_front();
                chk($sformatf("rnd%0d_strobe", k),
                    {43'h0, memory_push, memory_pop, busy, pc_valid, flags_valid, write_data},
                    {43'h0, b.ps, b.pp, !idle_now, nv_p, nv_f, b.wd});
                if (nv_p) chk($sformatf("rnd%0d_pc", k), {32'h0, pc_out}, {32'h0, e_pc});
                if (nv_f) chk($sformatf("rnd%0d_fl", k), {61'h0, flags_out}, {61'h0, e_fl});
                nv_p = (b.fin != 0);
                nv_f = (b.fin == 2);
                if (b.fin != 0) begin e_pc = b.pc; e_fl = b.fl; end

                // memory stage: pops read the current top, pushes land on it
                if (memory_pop) begin
                    mem_data_in = (mstk.size() > 0) ? mstk[mstk.size()-1] : 16'h0;
                    if (mstk.size() > 0) void'(mstk.pop_back());
                end
                if (memory_push) mstk.push_back(write_data);

                ir = ($urandom_range(0, 7) == 0);
                rr = ($urandom_range(0, 5) == 0);
                cr = ($urandom_range(0, 4) == 0);
                tr = ($urandom_range(0, 4) == 0);
                rpc = $urandom; rfl = 3'($urandom);
                {int_req, rti_req, call_req, ret_req} = {ir, rr, cr, tr};
                pc_in = rpc; flags_in = rfl;

                if (idle_now) begin
                    if (ir || pend) begin
                        pend = 0;
                        bq.push_back({1'b1, 1'b0, {13'h0, rfl}, 2'd0, 32'h0, 3'h0});
                        bq.push_back({1'b1, 1'b0, rpc[31:16], 2'd0, 32'h0, 3'h0});
                        bq.push_back({1'b1, 1'b0, rpc[15:0], 2'd0, 32'h0, 3'h0});
                        wstk.push_back({13'h0, rfl});
                        wstk.push_back(rpc[31:16]);
                        wstk.push_back(rpc[15:0]);
                    end else if (rr) begin
                        mpop(w0); mpop(w1); mpop(w2);
                        bq.push_back({1'b0, 1'b1, 16'h0, 2'd0, 32'h0, 3'h0});
                        bq.push_back({1'b0, 1'b1, 16'h0, 2'd0, 32'h0, 3'h0});
                        bq.push_back({1'b0, 1'b1, 16'h0, 2'd2, {w1, w0}, w2[2:0]});
                    end else if (cr) begin
                        bq.push_back({1'b1, 1'b0, rpc[31:16], 2'd0, 32'h0, 3'h0});
                        bq.push_back({1'b1, 1'b0, rpc[15:0], 2'd0, 32'h0, 3'h0});
                        wstk.push_back(rpc[31:16]);
                        wstk.push_back(rpc[15:0]);
                    end else if (tr) begin
                        mpop(w0); mpop(w1);
                        bq.push_back({1'b0, 1'b1, 16'h0, 2'd0, 32'h0, 3'h0});
                        bq.push_back({1'b0, 1'b1, 16'h0, 2'd1, {w1, w0}, 3'h0});
                    end
                end else if (ir) begin
                    pend = 1;
                end
                @(posedge clk); @(negedge clk);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
